// File: rtl/cu_port_arbiter.sv
// Two-requester round-robin arbiter for the single-beat CU register port; the owner keeps the grant while it requests.
// Read latency is 4 cycles with a 1-cycle CU. CU_ARB_TIMEOUT_EN adds a watchdog on the WAIT state.
module cu_port_arbiter #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rq0_rd_rqst_i,
    input  logic                  rq0_wr_rqst_i,
    input  logic [ADDR_WIDTH-1:0] rq0_addr_i,
    input  logic [DATA_WIDTH-1:0] rq0_wdata_i,
    input  logic                  rq1_rd_rqst_i,
    input  logic                  rq1_wr_rqst_i,
    input  logic [ADDR_WIDTH-1:0] rq1_addr_i,
    input  logic [DATA_WIDTH-1:0] rq1_wdata_i,
    output logic                  rq0_grant_o,
    output logic [DATA_WIDTH-1:0] rq0_rdata_o,
    output logic                  rq0_rdata_valid_o,
    output logic                  rq0_ack_o,
    output logic                  rq1_grant_o,
    output logic [DATA_WIDTH-1:0] rq1_rdata_o,
    output logic                  rq1_rdata_valid_o,
    output logic                  rq1_ack_o,
    output logic                  cu_rd_o,
    output logic                  cu_wr_o,
    output logic [ADDR_WIDTH-1:0] cu_addr_o,
    output logic [DATA_WIDTH-1:0] cu_wdata_o,
    input  logic [DATA_WIDTH-1:0] cu_rdata_i,
    input  logic                  cu_rdata_valid_i,
    input  logic                  cu_ack_i,
    output logic                  arb_timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_q, rr_d;
    logic                  op_wr_q, op_wr_d;
    logic                  grant0_q, grant0_d, grant1_q, grant1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  cu_rd_q, cu_rd_d, cu_wr_q, cu_wr_d;
    logic [ADDR_WIDTH-1:0] cu_addr_q, cu_addr_d;
    logic [DATA_WIDTH-1:0] cu_wdata_q, cu_wdata_d;

    logic                  req0, req1;
    logic                  own_req, own_wr;
    logic [ADDR_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0] own_wdata;
    logic                  resp, expire;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign req0      = rq0_rd_rqst_i | rq0_wr_rqst_i;
    assign req1      = rq1_rd_rqst_i | rq1_wr_rqst_i;
    assign own_req   = owner_q ? req1 : req0;
    assign own_wr    = owner_q ? rq1_wr_rqst_i : rq0_wr_rqst_i;
    assign own_addr  = owner_q ? rq1_addr_i : rq0_addr_i;
    assign own_wdata = owner_q ? rq1_wdata_i : rq0_wdata_i;

    // Only the response type matching the issued op counts; the other strobe is ignored.
    assign resp     = (state_q == S_WAIT) && (op_wr_q ? cu_ack_i : cu_rdata_valid_i);
    assign rsp_data = resp ? cu_rdata_i : '0;

`ifdef CU_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    assign expire = (state_q == S_WAIT) && (TIMEOUT_CYCLES != 0) &&
                    (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = (state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;
        tmo_d = expire && !resp;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign arb_timeout_o = tmo_q;
`else
    // The watchdog limit only matters when the timeout build is enabled.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire        = 1'b0;
    assign arb_timeout_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        op_wr_d    = op_wr_q;
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        cu_rd_d    = 1'b0;
        cu_wr_d    = 1'b0;
        cu_addr_d  = cu_addr_q;
        cu_wdata_d = cu_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // Pointer holder wins if requesting, otherwise the other side.
                    owner_d  = rr_q ? req1 : !req0;
                    grant0_d = !owner_d;
                    grant1_d = owner_d;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (own_req) begin
                    cu_addr_d  = own_addr;
                    cu_wdata_d = own_wdata;
                    op_wr_d    = own_wr;
                    cu_wr_d    = own_wr;
                    cu_rd_d    = !own_wr;
                    state_d    = S_WAIT;
                end else begin
                    grant0_d = 1'b0;
                    grant1_d = 1'b0;
                    rr_d     = !owner_q;
                    state_d  = S_IDLE;
                end
            end
            S_WAIT: begin
                if (resp || expire) begin
                    state_d = S_GAP;
                    if (op_wr_q) begin
                        ack0_d = !owner_q;
                        ack1_d = owner_q;
                    end else if (owner_q) begin
                        rdata1_d  = rsp_data;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = rsp_data;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            S_GAP:   state_d = S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            op_wr_q    <= 1'b0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            cu_rd_q    <= 1'b0;
            cu_wr_q    <= 1'b0;
            cu_addr_q  <= '0;
            cu_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            op_wr_q    <= op_wr_d;
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            cu_rd_q    <= cu_rd_d;
            cu_wr_q    <= cu_wr_d;
            cu_addr_q  <= cu_addr_d;
            cu_wdata_q <= cu_wdata_d;
        end
    end

    assign rq0_grant_o       = grant0_q;
    assign rq1_grant_o       = grant1_q;
    assign rq0_rdata_o       = rdata0_q;
    assign rq1_rdata_o       = rdata1_q;
    assign rq0_rdata_valid_o = rvalid0_q;
    assign rq1_rdata_valid_o = rvalid1_q;
    assign rq0_ack_o         = ack0_q;
    assign rq1_ack_o         = ack1_q;
    assign cu_rd_o           = cu_rd_q;
    assign cu_wr_o           = cu_wr_q;
    assign cu_addr_o         = cu_addr_q;
    assign cu_wdata_o        = cu_wdata_q;

endmodule
